// File: rtl/alu_op_issue.sv
// alu_op_issue
//   Decode/issue stage that feeds the EX-stage ALU of the five-stage MIPS
//   pipeline. The D-stage instruction is decoded into an ALU opcode, a
//   constant shift amount and the two operands, and all of them are
//   registered into the D->E pipeline register one cycle later. The
//   register honours the hazard unit's stall and flush requests. A
//   saturating counter tracks how many cycles the E stage carried a bubble.
//
// Ports
//   Clk        rising-edge clock
//   Reset      synchronous, active-high reset
//   Instr_D    D-stage instruction word
//   RS_D       GPR[rs] value, already forwarded
//   RT_D       GPR[rt] value, already forwarded
//   Valid_D    Instr_D holds a real instruction
//   Stall      hold the E register
//   Flush      insert a bubble into E
//   A_E        ALU operand A
//   B_E        ALU operand B
//   ALUOp_E    ALU opcode
//   S_E        constant shift amount
//   Valid_E    E-stage command is real
//   Illegal_E  E-stage instruction could not be decoded
//   BubbleCnt  cycles with Valid_E==0 since reset, saturating
module alu_op_issue #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      Instr_D,
  input  logic [31:0]      RS_D,
  input  logic [31:0]      RT_D,
  input  logic             Valid_D,
  input  logic             Stall,
  input  logic             Flush,
  output logic [31:0]      A_E,
  output logic [31:0]      B_E,
  output logic [5:0]       ALUOp_E,
  output logic [4:0]       S_E,
  output logic             Valid_E,
  output logic             Illegal_E,
  output logic [CNT_W-1:0] BubbleCnt
);

  // ALU opcode encoding understood by the EX stage
  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_XOR  = 6'd4;
  localparam logic [5:0] OP_SLL  = 6'd5;
  localparam logic [5:0] OP_SRL  = 6'd6;
  localparam logic [5:0] OP_SRA  = 6'd7;
  localparam logic [5:0] OP_LUI  = 6'd8;
  localparam logic [5:0] OP_SRAV = 6'd9;
  localparam logic [5:0] OP_PASS = 6'd11;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] imm_se;
  logic [31:0] imm_ze;

  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [5:0]  dec_op;
  logic [4:0]  dec_s;
  logic        dec_illegal;

  logic        next_valid;

  assign opcode = Instr_D[31:26];
  assign funct  = Instr_D[5:0];
  assign shamt  = Instr_D[10:6];
  assign imm_se = {{16{Instr_D[15]}}, Instr_D[15:0]};
  assign imm_ze = {16'h0000, Instr_D[15:0]};

  // Instruction decode. Every field the table does not name stays zero, and
  // an undecodable word becomes "pass B" with zero operands so that a
  // stray illegal instruction can never produce a meaningful ALU result.
  always_comb begin
    dec_a       = '0;
    dec_b       = '0;
    dec_op      = OP_PASS;
    dec_s       = '0;
    dec_illegal = 1'b0;
    unique case (opcode)
      6'h00: begin
        unique case (funct)
          6'h21: begin dec_op = OP_ADD;  dec_a = RS_D; dec_b = RT_D; end
          6'h23: begin dec_op = OP_SUB;  dec_a = RS_D; dec_b = RT_D; end
          6'h24: begin dec_op = OP_AND;  dec_a = RS_D; dec_b = RT_D; end
          6'h25: begin dec_op = OP_OR;   dec_a = RS_D; dec_b = RT_D; end
          6'h26: begin dec_op = OP_XOR;  dec_a = RS_D; dec_b = RT_D; end
          6'h00: begin dec_op = OP_SLL;  dec_b = RT_D; dec_s = shamt; end
          6'h02: begin dec_op = OP_SRL;  dec_b = RT_D; dec_s = shamt; end
          6'h03: begin dec_op = OP_SRA;  dec_b = RT_D; dec_s = shamt; end
          6'h07: begin dec_op = OP_SRAV; dec_a = RS_D; dec_b = RT_D; end
          default: dec_illegal = 1'b1;
        endcase
      end
      6'h09: begin dec_op = OP_ADD; dec_a = RS_D; dec_b = imm_se; end
      6'h0C: begin dec_op = OP_AND; dec_a = RS_D; dec_b = imm_ze; end
      6'h0D: begin dec_op = OP_OR;  dec_a = RS_D; dec_b = imm_ze; end
      6'h0E: begin dec_op = OP_XOR; dec_a = RS_D; dec_b = imm_ze; end
      6'h0F: begin dec_op = OP_LUI; dec_b = imm_ze; end
      6'h23, 6'h2B: begin dec_op = OP_ADD; dec_a = RS_D; dec_b = imm_se; end
      6'h04: begin dec_op = OP_SUB; dec_a = RS_D; dec_b = RT_D; end
      default: dec_illegal = 1'b1;
    endcase
    // Undecodable words must not leak partial operands from the decode above
    if (dec_illegal) begin
      dec_op = OP_PASS;
      dec_a  = '0;
      dec_b  = '0;
      dec_s  = '0;
    end
  end

  // Valid_E as it will be after the coming edge, used by the bubble counter
  // so that stall-held bubbles are counted as well as fresh ones.
  always_comb begin
    next_valid = Valid_D;
    if (Flush) begin
      next_valid = 1'b0;
    end else if (Stall) begin
      next_valid = Valid_E;
    end
  end

  // D->E pipeline register. A not-valid D instruction loads the same clean
  // bubble as a flush, so E never carries stale operands for a bubble.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      A_E       <= '0;
      B_E       <= '0;
      ALUOp_E   <= '0;
      S_E       <= '0;
      Valid_E   <= 1'b0;
      Illegal_E <= 1'b0;
    end else if (Flush || (!Stall && !Valid_D)) begin
      A_E       <= '0;
      B_E       <= '0;
      ALUOp_E   <= '0;
      S_E       <= '0;
      Valid_E   <= 1'b0;
      Illegal_E <= 1'b0;
    end else if (!Stall) begin
      A_E       <= dec_a;
      B_E       <= dec_b;
      ALUOp_E   <= dec_op;
      S_E       <= dec_s;
      Valid_E   <= 1'b1;
      Illegal_E <= dec_illegal;
    end
  end

  // Saturating bubble counter; only reset clears it
  always_ff @(posedge Clk) begin
    if (Reset) begin
      BubbleCnt <= '0;
    end else if (!next_valid && (BubbleCnt != {CNT_W{1'b1}})) begin
      BubbleCnt <= BubbleCnt + 1'b1;
    end
  end

endmodule
